// File: rtl/mcycle_unit_pkg.sv
// Shared encodings for the multi-cycle multiply/divide unit: operation codes,
// FSM state encoding and small decode helpers.
package mcycle_unit_pkg;

    // MCycleOp: bit1 selects divide, bit0 selects signed arithmetic.
    typedef enum logic [1:0] {
        MUL_U = 2'b00,
        MUL_S = 2'b01,
        DIV_U = 2'b10,
        DIV_S = 2'b11
    } mcycle_op_t;

    // Controller states; exported on the debug port of the unit.
    typedef enum logic [1:0] {
        S_IDLE      = 2'b00,
        S_COMPUTING = 2'b01,
        S_DONE      = 2'b10
    } state_t;

    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return op[0];
    endfunction

endpackage

// File: rtl/mcycle_unit_if.sv
// Request/result bundle between the instruction decoder and the multi-cycle unit.
//
// Handshake: Start is a level request that the decoder holds high for the whole
// instruction. M_Busy is high in the Start cycle itself (while the unit is idle)
// and for every computing cycle after it, so the PC stalls for the full
// operation. The cycle in which M_Busy falls is the DONE cycle: Result1/Result2
// are valid there and stay unchanged until the next operation completes. Inputs
// are sampled only on the edge that leaves IDLE.
interface mcycle_unit_if #(
    parameter int WIDTH = 32
);
    logic             Start;
    logic [1:0]       MCycleOp;
    logic [WIDTH-1:0] Operand1;
    logic [WIDTH-1:0] Operand2;
    logic [WIDTH-1:0] Result1;
    logic [WIDTH-1:0] Result2;
    logic             M_Busy;

    // Decoder side.
    modport master (
        output Start, MCycleOp, Operand1, Operand2,
        input  Result1, Result2, M_Busy
    );

    // Arithmetic unit side.
    modport slave (
        input  Start, MCycleOp, Operand1, Operand2,
        output Result1, Result2, M_Busy
    );
endinterface

// File: rtl/mcycle_unit.sv
// Multi-cycle multiply/divide unit. One shared (WIDTH+1)-bit adder serves both
// the shift-add multiplier and the restoring divider; operands are reduced to
// magnitudes on capture and the signs are re-applied on the final iteration.
module mcycle_unit
    import mcycle_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic          CLK,
    input  logic          Reset,
    mcycle_unit_if.slave  bus,
    output state_t        dbg_state
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t               state;
    logic [CW-1:0]        cnt;
    logic [2*WIDTH:0]     acc;        // {upper (WIDTH+1), lower (WIDTH)}
    logic [WIDTH-1:0]     opb_q;      // multiplicand or divisor magnitude
    logic                 is_div_q;
    logic                 neg_q;      // negate product / quotient
    logic                 neg_rem_q;  // negate remainder (dividend sign)
    logic                 div_zero_q;
    logic [WIDTH-1:0]     result1_q;
    logic [WIDTH-1:0]     result2_q;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic sgn);
        return (sgn && x[WIDTH-1]) ? (~x + 1'b1) : x;
    endfunction

    logic             in_signed;
    logic             in_div;
    logic             a_neg;
    logic             b_neg;
    logic             b_zero;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;

    // Decode of the request as presented in the Start cycle.
    always_comb begin
        in_signed = op_is_signed(bus.MCycleOp);
        in_div    = op_is_div(bus.MCycleOp);
        a_neg     = in_signed & bus.Operand1[WIDTH-1];
        b_neg     = in_signed & bus.Operand2[WIDTH-1];
        b_zero    = (bus.Operand2 == '0);
        mag_a     = mag(bus.Operand1, in_signed);
        mag_b     = mag(bus.Operand2, in_signed);
    end

    logic [2*WIDTH:0] shifted;
    logic [WIDTH:0]   add_a;
    logic [WIDTH:0]   add_b;
    logic             add_cin;
    logic [WIDTH:0]   sum;
    logic [2*WIDTH:0] acc_next;

    // One iteration of the shared datapath: shift-add or restoring shift-subtract.
    always_comb begin
        shifted = {acc[2*WIDTH-1:0], 1'b0};
        if (is_div_q) begin
            add_a   = shifted[2*WIDTH:WIDTH];
            add_b   = ~{1'b0, opb_q};
            add_cin = 1'b1;
        end else begin
            add_a   = acc[2*WIDTH:WIDTH];
            add_b   = acc[0] ? {1'b0, opb_q} : '0;
            add_cin = 1'b0;
        end
        sum = add_a + add_b + {{WIDTH{1'b0}}, add_cin};
        if (is_div_q) begin
            // Top bit of the difference set means the trial went negative: restore.
            if (!sum[WIDTH]) begin
                acc_next = {sum, shifted[WIDTH-1:1], 1'b1};
            end else begin
                acc_next = shifted;
            end
        end else begin
            acc_next = {1'b0, sum, acc[WIDTH-1:1]};
        end
    end

    logic [2*WIDTH-1:0] product;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;

    // Sign correction applied to the outcome of the final iteration.
    always_comb begin
        product  = acc_next[2*WIDTH-1:0];
        prod_fix = neg_q ? (~product + 1'b1) : product;
        if (div_zero_q) begin
            quot_fix = '1;
        end else begin
            quot_fix = neg_q ? (~acc_next[WIDTH-1:0] + 1'b1) : acc_next[WIDTH-1:0];
        end
        rem_fix = neg_rem_q ? (~acc_next[2*WIDTH-1:WIDTH] + 1'b1) : acc_next[2*WIDTH-1:WIDTH];
    end

    // Controller, iteration counter, operand capture and result registers.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            acc        <= '0;
            opb_q      <= '0;
            is_div_q   <= 1'b0;
            neg_q      <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
            result1_q  <= '0;
            result2_q  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.Start) begin
                        is_div_q   <= in_div;
                        neg_q      <= (a_neg ^ b_neg) & ~(in_div & b_zero);
                        neg_rem_q  <= a_neg;
                        div_zero_q <= in_div & b_zero;
                        opb_q      <= in_div ? mag_b : mag_a;
                        acc        <= {{(WIDTH+1){1'b0}}, (in_div ? mag_a : mag_b)};
                        cnt        <= '0;
                        state      <= S_COMPUTING;
                    end
                end
                S_COMPUTING: begin
                    acc <= acc_next;
                    cnt <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        result1_q <= is_div_q ? quot_fix : prod_fix[WIDTH-1:0];
                        result2_q <= is_div_q ? rem_fix  : prod_fix[2*WIDTH-1:WIDTH];
                        state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.M_Busy  = ((state == S_IDLE) && bus.Start) || (state == S_COMPUTING);
    assign bus.Result1 = result1_q;
    assign bus.Result2 = result2_q;
    assign dbg_state   = state;

endmodule

// File: doc/mcycle_unit.md
MCYCLE_UNIT -- requirements
Module: mcycle_unit

Interface
REQ-001 Parameter WIDTH, default 32, operand and result width in bits.
REQ-002 CLK  input  1  single clock; all state updates on rising edge.
REQ-003 Reset  input  1  asynchronous, active-high reset.
REQ-004 Start  input  1  request multi-cycle operation; held high by the decoder for the whole instruction.
REQ-005 MCycleOp  input  2  bit1: 0 multiply, 1 divide; bit0: 1 signed, 0 unsigned.
REQ-006 Operand1  input  WIDTH  multiplicand or dividend.
REQ-007 Operand2  input  WIDTH  multiplier or divisor.
REQ-008 Result1  output  WIDTH  product low half or quotient.
REQ-009 Result2  output  WIDTH  product high half or remainder.
REQ-010 M_Busy  output  1  high while the operation is in progress; the program counter holds while it is high.

Function
REQ-011 States SHALL be IDLE, COMPUTING and DONE.
REQ-012 M_Busy SHALL equal (IDLE and Start) or COMPUTING, combinationally, so the PC stalls in the Start cycle itself.
REQ-013 IDLE with Start high: the next edge SHALL capture Operand1, Operand2 and MCycleOp (magnitudes when signed), clear the iteration counter and enter COMPUTING.
REQ-014 COMPUTING SHALL perform one shift-add (multiply) or one restoring shift-subtract (divide) iteration per cycle.
REQ-015 On the edge where the counter equals WIDTH-1, the block SHALL perform the final iteration, apply sign correction, register Result1/Result2 and enter DONE.
REQ-016 M_Busy SHALL be high for exactly WIDTH+1 consecutive cycles per operation (33 when WIDTH=32).
REQ-017 DONE SHALL drive M_Busy low with results valid, then return to IDLE on the next edge regardless of Start, so a held Start does not retrigger.
REQ-018 Result1/Result2 SHALL hold their last value in IDLE and COMPUTING until overwritten.
REQ-019 Changes on Operand1/Operand2/MCycleOp/Start during COMPUTING SHALL be ignored.
REQ-020 Multiply SHALL produce the full 2*WIDTH-bit product: signed two's-complement for op 01, unsigned for op 00.
REQ-021 Signed divide SHALL truncate toward zero; the remainder SHALL take the sign of the dividend.
REQ-022 Divide by zero SHALL give Result1 all-ones and Result2 equal to Operand1, for both signedness values, with the normal WIDTH+1 busy cycles.
REQ-023 Signed most-negative / -1 SHALL give Result1 equal to the most-negative value and Result2 equal to 0.
REQ-024 Internal datapath SHALL be 2*WIDTH+1 bits wide where needed; no result bit is lost.

Reset
REQ-025 Reset high SHALL force IDLE, counter 0, Result1=0, Result2=0 and M_Busy=0 (when Start is low) immediately, independent of CLK.
REQ-026 Reset asserted mid-COMPUTING SHALL abort the operation; no partial result becomes visible.
REQ-027 After Reset deasserts with Start high, a new operation SHALL begin on the first edge.

Structure
REQ-028 A shared package SHALL hold the MCycleOp encodings (MUL_U=00, MUL_S=01, DIV_U=10, DIV_S=11) and the state encoding.
REQ-029 The block SHALL be a single module containing the FSM, counter, and shared shift/add-subtract datapath; no sub-module is required.

Verification
REQ-030 Unsigned mul, WIDTH=32: Start, op 00, 0xFFFFFFFF*0xFFFFFFFF -> M_Busy high 33 cycles; then Result1=0x00000001, Result2=0xFFFFFFFE.
REQ-031 Signed mul: op 01, -7*6 -> Result1=0xFFFFFFD6, Result2=0xFFFFFFFF.
REQ-032 Signed div: op 11, -7/2 -> Result1=0xFFFFFFFD, Result2=0xFFFFFFFF; unsigned div, op 10, 100/7 -> Result1=14, Result2=2.
REQ-033 Divide by zero: op 10, 0x1234/0 -> Result1=0xFFFFFFFF, Result2=0x1234 after 33 busy cycles.
REQ-034 Start held high across DONE -> exactly one operation; M_Busy low for one DONE cycle, then high again only if Start is still high in IDLE.
REQ-035 Reset pulsed in busy cycle 10 -> M_Busy low and results 0 at once; an operation restarted afterwards completes correctly.
